// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 64;

    localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hD440_0000;
    localparam logic [INSTR_W-1:0] NOP_BUBBLE = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               valid;
    } ifid_t;

    function automatic ifid_t ifid_bubble();
        ifid_t b;
        b.instr = NOP_BUBBLE;
        b.pc    = '0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with load enable and sequential/branch next-PC mux.
module fetch_pc #(
    parameter int unsigned   N        = 64,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_en,
    input  logic         sel_branch,
    input  logic [N-1:0] pc_branch,
    output logic [N-1:0] pc
);

    logic [N-1:0] pc_next_c;

    always_comb begin
        pc_next_c = sel_branch ? pc_branch : pc + N'(4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load_en) begin
            pc <= pc_next_c;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: owns the PC, addresses imem and fills the IF/ID register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned   N          = 64,
    parameter int unsigned   ADDR_W     = 6,
    parameter logic [N-1:0]  RESET_PC   = '0,
    parameter logic [31:0]   HALT_INSTR = fetch_pkg::HALT_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_q,
    input  logic              stall_d,
    input  logic              flush_d,
    input  logic              pc_src,
    input  logic [N-1:0]      pc_branch,
    output logic [31:0]       instr_d,
    output logic [N-1:0]      pc_d,
    output logic              valid_d,
    output logic              halted,
    output logic              fault
);

    fetch_state_t state_q, state_n;
    ifid_t        ifid_q, ifid_n;
    logic [N-1:0] pc;
    logic         pc_load;
    logic         pc_sel_branch;
    logic         bad_pc_c;

    fetch_pc #(
        .N        (N),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load_en    (pc_load),
        .sel_branch (pc_sel_branch),
        .pc_branch  (pc_branch),
        .pc         (pc)
    );

    assign imem_addr = pc[ADDR_W+1:2];

    // PC must be word aligned and inside the imem window
    assign bad_pc_c = (|pc[1:0]) || (|pc[N-1:ADDR_W+2]);

    always_comb begin
        state_n       = state_q;
        ifid_n        = ifid_q;
        pc_load       = 1'b0;
        pc_sel_branch = 1'b0;

        unique case (state_q)
            RUN: begin
                if (pc_src) begin
                    pc_load       = 1'b1;
                    pc_sel_branch = 1'b1;
                    ifid_n        = ifid_bubble();
                end else if (bad_pc_c) begin
                    state_n      = FAULT;
                    ifid_n.valid = 1'b0;
                end else if (flush_d) begin
                    ifid_n  = ifid_bubble();
                    pc_load = !stall_d;
                end else if (!stall_d) begin
                    ifid_n.instr = imem_q;
                    ifid_n.pc    = PC_W'(pc);
                    ifid_n.valid = 1'b1;
                    // the halt word itself is delivered to decode, then fetch freezes
                    if (imem_q == HALT_INSTR) begin
                        state_n = HALT;
                    end else begin
                        pc_load = 1'b1;
                    end
                end
            end
            HALT, FAULT: begin
                if (pc_src) begin
                    state_n       = RUN;
                    pc_load       = 1'b1;
                    pc_sel_branch = 1'b1;
                    ifid_n        = ifid_bubble();
                end else begin
                    ifid_n.valid = 1'b0;
                end
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            ifid_q  <= '0;
            halted  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state_q <= state_n;
            ifid_q  <= ifid_n;
            halted  <= (state_n == HALT);
            fault   <= (state_n == FAULT);
        end
    end

    assign instr_d = ifid_q.instr;
    assign pc_d    = N'(ifid_q.pc);
    assign valid_d = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a word-addressed imem model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic        stall_d;
    logic        flush_d;
    logic        pc_src;
    logic [63:0] pc_branch;
    logic [31:0] instr_d;
    logic [63:0] pc_d;
    logic        valid_d;
    logic        halted;
    logic        fault;

    logic [31:0] mem [64];
    int          n_total;
    int          n_pass;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        src;
        logic [63:0] br;
        logic [5:0]  addr;
        logic [31:0] instr;
        logic [63:0] pcd;
        logic        valid;
        logic        hlt;
        logic        flt;
    } vec_t;

    vec_t vq[$];

    localparam logic [31:0] HLT = 32'hD440_0000;

    fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_q    (imem_q),
        .stall_d   (stall_d),
        .flush_d   (flush_d),
        .pc_src    (pc_src),
        .pc_branch (pc_branch),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .valid_d   (valid_d),
        .halted    (halted),
        .fault     (fault)
    );

    assign imem_q = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        reset     = v.rst;
        stall_d   = v.stall;
        flush_d   = v.flush;
        pc_src    = v.src;
        pc_branch = v.br;
        @(posedge clk);
        #1;
        chk("imem_addr", idx, 64'(imem_addr), 64'(v.addr));
        chk("instr_d",   idx, 64'(instr_d),   64'(v.instr));
        chk("pc_d",      idx, pc_d,           v.pcd);
        chk("valid_d",   idx, 64'(valid_d),   64'(v.valid));
        chk("halted",    idx, 64'(halted),    64'(v.hlt));
        chk("fault",     idx, 64'(fault),     64'(v.flt));
    endtask

    // rst stall flush src br | addr instr pc_d valid halted fault
    task automatic add(input logic r, input logic s, input logic f, input logic p, input logic [63:0] b,
                       input logic [5:0] a, input logic [31:0] i, input logic [63:0] d,
                       input logic v, input logic h, input logic x);
        vq.push_back('{r, s, f, p, b, a, i, d, v, h, x});
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[5] = HLT;

        reset = 1'b1; stall_d = 1'b0; flush_d = 1'b0; pc_src = 1'b0; pc_branch = '0;

        // sequential fetch from reset
        add(0,0,0,0, 64'h0,   6'd1,  32'h1000_0000, 64'h00, 1,0,0);
        add(0,0,0,0, 64'h0,   6'd2,  32'h1000_0001, 64'h04, 1,0,0);
        add(0,0,0,0, 64'h0,   6'd3,  32'h1000_0002, 64'h08, 1,0,0);
        add(0,0,0,0, 64'h0,   6'd4,  32'h1000_0003, 64'h0C, 1,0,0);
        // stall at PC 0x10
        add(0,1,0,0, 64'h0,   6'd4,  32'h1000_0003, 64'h0C, 1,0,0);
        add(0,1,0,0, 64'h0,   6'd4,  32'h1000_0003, 64'h0C, 1,0,0);
        add(0,1,0,0, 64'h0,   6'd4,  32'h1000_0003, 64'h0C, 1,0,0);
        add(0,0,0,0, 64'h0,   6'd5,  32'h1000_0004, 64'h10, 1,0,0);
        // halt word at 0x14
        add(0,0,0,0, 64'h0,   6'd5,  HLT,           64'h14, 1,1,0);
        add(0,0,0,0, 64'h0,   6'd5,  HLT,           64'h14, 0,1,0);
        add(0,1,1,0, 64'h0,   6'd5,  HLT,           64'h14, 0,1,0);
        add(0,0,0,1, 64'h8,   6'd2,  32'h0,         64'h00, 0,0,0);
        add(0,0,0,0, 64'h0,   6'd3,  32'h1000_0002, 64'h08, 1,0,0);
        // redirect beats stall
        add(0,1,0,1, 64'h40,  6'd16, 32'h0,         64'h00, 0,0,0);
        add(0,0,0,0, 64'h0,   6'd17, 32'h1000_0010, 64'h40, 1,0,0);
        // flush with and without stall
        add(0,0,0,1, 64'h8,   6'd2,  32'h0,         64'h00, 0,0,0);
        add(0,1,1,0, 64'h0,   6'd2,  32'h0,         64'h00, 0,0,0);
        add(0,0,1,0, 64'h0,   6'd3,  32'h0,         64'h00, 0,0,0);
        add(0,0,0,0, 64'h0,   6'd4,  32'h1000_0003, 64'h0C, 1,0,0);
        // misaligned target, then out-of-range target
        add(0,0,0,1, 64'h102, 6'd0,  32'h0,         64'h00, 0,0,0);
        add(0,0,0,0, 64'h0,   6'd0,  32'h0,         64'h00, 0,0,1);
        add(0,1,1,0, 64'h0,   6'd0,  32'h0,         64'h00, 0,0,1);
        add(0,0,0,1, 64'h100, 6'd0,  32'h0,         64'h00, 0,0,0);
        add(0,0,0,0, 64'h0,   6'd0,  32'h0,         64'h00, 0,0,1);
        add(1,0,0,0, 64'h0,   6'd0,  32'h0,         64'h00, 0,0,0);
        add(0,0,0,0, 64'h0,   6'd1,  32'h1000_0000, 64'h00, 1,0,0);

        // reset held two cycles
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_addr",   -1, 64'(imem_addr), 64'h0);
        chk("rst_instr",  -1, 64'(instr_d),   64'h0);
        chk("rst_pc_d",   -1, pc_d,           64'h0);
        chk("rst_valid",  -1, 64'(valid_d),   64'h0);
        chk("rst_halted", -1, 64'(halted),    64'h0);
        chk("rst_fault",  -1, 64'(fault),     64'h0);

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // redirect landing while the halt word is on imem_q: no halt
        apply('{0,0,0,1, 64'h14, 6'd5, 32'h0,         64'h00, 0,0,0}, 100);
        apply('{0,0,0,1, 64'h20, 6'd8, 32'h0,         64'h00, 0,0,0}, 101);
        apply('{0,0,0,0, 64'h0,  6'd9, 32'h1000_0008, 64'h20, 1,0,0}, 102);
        // mid-run reset overrides a redirect on the same edge
        apply('{1,0,0,1, 64'h40, 6'd0, 32'h0,         64'h00, 0,0,0}, 103);
        apply('{0,0,0,0, 64'h0,  6'd1, 32'h1000_0000, 64'h00, 1,0,0}, 104);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 pipeline; sits directly upstream of imem.
- Owns the program counter and drives the imem word address.
- Captures the imem read data into the IF/ID pipeline register for decode.
- Handles decode stalls, branch redirects and flushes, and detects halt and fetch-fault conditions.

Parameters:
N, 64, PC and branch-target width
ADDR_W, 6, imem word-address width (64 words)
RESET_PC, 64'h0, PC value loaded on reset
HALT_INSTR, 32'hD4400000, encoding that stops fetch (HLT #0)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
imem_addr  out  ADDR_W  word address to imem; combinational, equals PC[ADDR_W+1:2]
imem_q  in  32  imem read data; combinational in the same cycle
stall_d  in  1  decode stall: hold PC and IF/ID
flush_d  in  1  squash: IF/ID becomes a bubble
pc_src  in  1  redirect request from branch resolution
pc_branch  in  N  redirect target
instr_d  out  32  IF/ID instruction
pc_d  out  N  IF/ID PC of instr_d
valid_d  out  1  IF/ID entry valid
halted  out  1  state == HALT
fault  out  1  state == FAULT

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values: PC=RESET_PC, state=RUN, instr_d=0, pc_d=0, valid_d=0, halted=0, fault=0.
- Fetch latency: the instruction at PC appears on instr_d one cycle after PC is presented.
- State RUN:
  - Bad-PC check on the current PC: PC[1:0]!=0, or PC[N-1:ADDR_W+2]!=0.
  - Bad PC and no pc_src: next state FAULT, valid_d<=0, PC holds.
  - Priority otherwise: pc_src > flush_d > stall_d > normal.
  - pc_src=1: PC<=pc_branch and IF/ID<=bubble (instr_d=0, pc_d=0, valid_d=0), regardless of stall_d or flush_d.
  - flush_d=1, pc_src=0: IF/ID<=bubble; PC advances by 4 unless stall_d=1.
  - stall_d=1 only: PC and IF/ID hold all fields unchanged.
  - Normal: PC<=PC+4 (modulo 2^N; no wrap detection beyond the bad-PC check); IF/ID<={imem_q, PC, 1}.
  - In the normal case, if imem_q==HALT_INSTR: still latched with valid_d=1, next state HALT, PC holds (no +4).
- State HALT:
  - valid_d<=0 from the next cycle; PC frozen; stall_d and flush_d have no effect.
  - pc_src=1 (halt was speculative): PC<=pc_branch, state RUN, IF/ID bubble.
- State FAULT:
  - Same as HALT: frozen and sticky.
  - pc_src=1 exits to RUN with PC<=pc_branch.
- Simultaneous events:
  - A redirect in the same cycle as a halt fetch: redirect wins, no halt.
  - reset asserted mid-operation overrides everything on that edge.
- halted and fault are registered-state decodes, never both 1.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {RUN, HALT, FAULT}
  - localparam HALT_INSTR
  - localparam NOP_BUBBLE = 32'h0
  - Shared IF/ID struct typedef {instr, pc, valid}
- Sub-module fetch_pc: N-bit PC register with synchronous reset to RESET_PC, load-enable, and next-PC mux (PC+4 / pc_branch). Reusable later by a prediction stage.

Test Plan:
- Reset held 2 cycles then released, imem preloaded with distinct words -> imem_addr 0,1,2,...; instr_d follows one cycle later; pc_d = 0,4,8; valid_d=1 from cycle 2.
- stall_d=1 for 3 cycles at PC=0x10 -> imem_addr stays 4; instr_d/pc_d/valid_d unchanged; on release, fetch resumes at 0x10 then 0x14.
- pc_src=1 with pc_branch=0x40 while stall_d=1 -> next cycle valid_d=0, imem_addr=16; following cycle pc_d=0x40.
- Word 5 = 32'hD4400000 -> pc_d=0x14, valid_d=1, halted=1 next cycle; afterwards valid_d=0 and imem_addr frozen at 5. pc_src with target 0x8 -> halted=0, fetch resumes at 0x8.
- pc_branch=0x102 (misaligned), then separately 0x100 (beyond 64 words) -> fault=1 one cycle after PC load, valid_d=0, PC frozen. Reset clears fault; PC=0.
- flush_d=1 and stall_d=1 together at PC=0x8 -> valid_d=0, instr_d=0, PC stays 0x8.
